// File: rtl/edge_pixel_source_pkg.sv
// Shared types and constants for the edge-detection pixel source.
package edge_pixel_source_pkg;

  localparam int ROW_NUM_DEF = 480;
  localparam int COL_NUM_DEF = 640;

  typedef logic signed [10:0] coord_t;
  typedef logic [7:0]         pixel_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Clamp one axis into [0, lim-1].
  function automatic coord_t clamp_coord(input coord_t c, input coord_t lim);
    if (c < 0)    return '0;
    if (c >= lim) return lim - coord_t'(1);
    return c;
  endfunction

endpackage

// File: rtl/edge_pixel_source_coord_mapper.sv
// Bounds check and frame-address computation for one (x, y) request.
// EDGE_BORDER_REPLICATE_EN: clamp out-of-frame coordinates instead of flagging them.
module edge_pixel_source_coord_mapper
  import edge_pixel_source_pkg::*;
#(
  parameter int ROW_NUM   = ROW_NUM_DEF,
  parameter int COL_NUM   = COL_NUM_DEF,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic signed [10:0] x,
  input  logic signed [10:0] y,
  output logic               in_bounds,
  output logic [ADDR_W-1:0]  addr
);

  localparam coord_t COL_LIM = coord_t'(COL_NUM);
  localparam coord_t ROW_LIM = coord_t'(ROW_NUM);

  coord_t xc;
  coord_t yc;

  always_comb begin
`ifdef EDGE_BORDER_REPLICATE_EN
    xc        = clamp_coord(x, COL_LIM);
    yc        = clamp_coord(y, ROW_LIM);
    in_bounds = 1'b1;
`else
    xc        = x;
    yc        = y;
    in_bounds = !x[10] && (x < COL_LIM) && !y[10] && (y < ROW_LIM);
`endif
    // Coordinates are non-negative here, so the unsigned widening is exact.
    if (in_bounds)
      addr = ADDR_W'(BASE_ADDR) + ADDR_W'($unsigned(yc)) * ADDR_W'(COL_NUM)
             + ADDR_W'($unsigned(xc));
    else
      addr = '0;
  end

endmodule

// File: rtl/edge_pixel_source.sv
// Pixel responder: answers (x, y) requests from a one-entry cache, zero padding or a memory read.
// EDGE_BORDER_REPLICATE_EN selects border replication instead of zero padding.
//
// state | meaning
// IDLE  | ready; en sampled here only
// ISSUE | mem_read held until mem_waitrequest drops
// WAIT  | read accepted, waiting for readdatavalid
// DRAIN | read aborted by sync, discard the pending readdatavalid
// RESP  | pixel_valid pulse
module edge_pixel_source
  import edge_pixel_source_pkg::*;
#(
  parameter int ROW_NUM   = ROW_NUM_DEF,
  parameter int COL_NUM   = COL_NUM_DEF,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic signed [10:0] next_pixel_x,
  input  logic signed [10:0] next_pixel_y,
  output logic               waitrequest,
  output logic [7:0]         pixel,
  output logic               pixel_valid,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_read,
  input  logic               mem_waitrequest,
  input  logic [7:0]         mem_readdata,
  input  logic               mem_readdatavalid
);

  logic [2:0]        state;
  logic              in_bounds;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] last_addr;
  pixel_t            last_pix;
  logic              last_valid;

  edge_pixel_source_coord_mapper #(
    .ROW_NUM  (ROW_NUM),
    .COL_NUM  (COL_NUM),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_mapper (
    .x        (next_pixel_x),
    .y        (next_pixel_y),
    .in_bounds(in_bounds),
    .addr     (req_addr)
  );

  assign waitrequest = (state != ST_IDLE);
  assign pixel_valid = (state == ST_RESP);
  assign mem_read    = (state == ST_ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pixel       <= '0;
      mem_address <= '0;
      last_addr   <= '0;
      last_pix    <= '0;
      last_valid  <= 1'b0;
    end else begin
      if (sync) last_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && !sync) begin
            if (!in_bounds) begin
              pixel <= '0;
              state <= ST_RESP;
            end else if (last_valid && (req_addr == last_addr)) begin
              pixel <= last_pix;
              state <= ST_RESP;
            end else begin
              mem_address <= req_addr;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A sync on the accepting cycle still leaves one readdatavalid in flight.
          if (sync)                  state <= mem_waitrequest ? ST_IDLE : ST_DRAIN;
          else if (!mem_waitrequest) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sync) begin
            state <= mem_readdatavalid ? ST_IDLE : ST_DRAIN;
          end else if (mem_readdatavalid) begin
            pixel      <= mem_readdata;
            last_addr  <= mem_address;
            last_pix   <= mem_readdata;
            last_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (mem_readdatavalid) state <= ST_IDLE;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/edge_pixel_source.md
Name: edge_pixel_source

Overview:
Pixel responder feeding the edge-detection pipeline.
- Accepts signed (x, y) coordinate requests from the detector.
- Fetches the 8-bit pixel from frame memory over an Avalon-MM style read master and returns it with a done pulse.
- Out-of-frame coordinates are answered locally, with no memory traffic.
- A one-entry last-pixel register avoids refetching a repeated coordinate.

Parameters:
ROW_NUM, 480, frame height in pixels
COL_NUM, 640, frame width in pixels
ADDR_W, 19, memory address width (must cover ROW_NUM*COL_NUM)
BASE_ADDR, 0, frame base address in memory

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
en  in  1  request strobe; coordinates valid; sampled only in IDLE
sync  in  1  frame boundary; invalidates last-pixel register, aborts outstanding fetch
next_pixel_x  in  11 signed  requested column
next_pixel_y  in  11 signed  requested row
waitrequest  out  1  high while a request is in flight (state != IDLE)
pixel  out  8  returned pixel; valid only when pixel_valid=1
pixel_valid  out  1  one-cycle response pulse
mem_address  out  ADDR_W  BASE_ADDR + y*COL_NUM + x
mem_read  out  1  read command; held until accepted
mem_waitrequest  in  1  memory stall
mem_readdata  in  8  read data
mem_readdatavalid  in  1  read data valid; never in the same cycle the read is accepted

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, waitrequest=0, pixel=0, pixel_valid=0, mem_read=0, mem_address=0, last-pixel valid=0.
- waitrequest is decoded from registered state only; it is never combinational on en.
- IDLE, en=1, classified by bounds check and last-pixel register:
  - Out-of-bounds (x<0, x>=COL_NUM, y<0 or y>=ROW_NUM): pixel=0, go to RESP.
  - In-bounds, address equals the stored last address and last-valid=1: pixel=stored value, go to RESP.
  - Otherwise: register the address, go to ISSUE.
- ISSUE: mem_read=1 with a stable mem_address. When mem_waitrequest=0, the read is accepted; go to WAIT.
- WAIT: on mem_readdatavalid, capture pixel, update last address/value, set last-valid=1, go to RESP.
- RESP: pixel_valid=1 for exactly one cycle, pixel stable, then IDLE.
- Requests are accepted only in IDLE; en is ignored in every other state.
- Back-to-back requests: the minimum request-to-request period is 2 cycles (hit/OOB) and 4 cycles (miss with zero-wait memory).
- Latency from the en cycle to pixel_valid:
  - Hit or OOB: 1 cycle.
  - Miss: 3 cycles plus mem_waitrequest stall cycles plus extra readdatavalid delay.
- sync handling:
  - Any state: clears last-valid.
  - ISSUE, read not yet accepted: drop mem_read, go to IDLE, no response.
  - ISSUE on the accepting cycle, or WAIT: go to DRAIN. DRAIN discards the next mem_readdatavalid, then goes to IDLE, no response and no last-pixel update.
  - RESP: the response still completes.
  - sync together with en in IDLE: sync wins; the request is not accepted.
- Address arithmetic:
  - y*COL_NUM+x is computed unsigned in ADDR_W bits, only after the bounds check passes.
  - There is no wrap-around. The coordinate (COL_NUM-1, ROW_NUM-1) maps to BASE_ADDR+ROW_NUM*COL_NUM-1.

Optional Feature:
EDGE_BORDER_REPLICATE_EN
- Defined: out-of-bounds coordinates are clamped per axis (negative→0, >=limit→limit-1) and served as normal in-bounds requests. These go through the hit check, then a fetch if needed.
- Undefined: out-of-bounds returns 0 with 1-cycle latency (zero padding).

Decomposition:
- Shared package (EdgeDetectionPackage):
  - ROW_NUM/COL_NUM defaults
  - signed 11-bit coordinate typedef
  - state enum {IDLE, ISSUE, WAIT, DRAIN, RESP}
  - pixel typedef (8-bit)
- Sub-module edge_coord_mapper (combinational): bounds check, optional clamp, address computation.

Test Plan:
- Request (5,2), zero-wait memory, readdatavalid 1 cycle after accept, data 0x3C → mem_address=BASE+1285, pixel_valid on cycle 3, pixel=0x3C.
- Repeat (5,2) immediately → no mem_read, pixel_valid on cycle 1, pixel=0x3C.
- Request (-1,0) and (640,479) → no mem_read, pixel=0 after 1 cycle. With EDGE_BORDER_REPLICATE_EN: reads at addresses BASE+0 and BASE+307199.
- Request (639,479) with mem_waitrequest held 4 cycles → mem_read and mem_address stable throughout, waitrequest=1 until RESP, pixel_valid on cycle 7.
- sync during WAIT, late readdatavalid 0xAA → no pixel_valid. A following (5,2) request refetches from memory (miss), and 0xAA is never returned.
- rst low mid-ISSUE → all outputs 0 immediately. After release, a first request to the previous address misses.
